wall_map_writer: RTL

//  Owns the tile map RAM of the playfield: one 4-bit sprite code per 32x32 tile, MAP_W x MAP_H tiles.

---
 rtl/wall_map_writer.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/wall_map_writer.sv
`default_nettype none
// ============================================================================
// Module   : wall_map_writer
// Purpose  : Playfield tile-map RAM with power-on fill sweep, an explosion
//            engine that clears bricks along four blast arms, and a
//            registered renderer read port. Optional macro WALL_MAP_RANDOM_EN
//            selects LFSR-driven brick placement.
// Revision : 1.0 - initial release
// ============================================================================
module wall_map_writer #(
    parameter int         MAP_W      = 20,
    parameter int         MAP_H      = 15,
    parameter logic [3:0] TILE_EMPTY = 4'd0,
    parameter logic [3:0] TILE_SOLID = 4'd1,
    parameter logic [3:0] TILE_BRICK = 4'd2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rd_tileX,
    input  logic [3:0] rd_tileY,
    output logic [3:0] rd_sprite,
    output logic       init_done,
    input  logic       expl_valid,
    output logic       expl_ready,
    input  logic [4:0] expl_tileX,
    input  logic [3:0] expl_tileY,
    input  logic [2:0] expl_range,
    output logic       destroyed_valid,
    output logic [4:0] destroyed_tileX,
    output logic [3:0] destroyed_tileY
);

    typedef enum logic [1:0] {
        S_INIT    = 2'd0,
        S_IDLE    = 2'd1,
        S_ARM_RD  = 2'd2,
        S_ARM_CHK = 2'd3
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_mem [0:511];
    logic [3:0]  r_rd_sprite, r_eng_q;
    logic        r_init_done, r_destroyed_valid;
    logic [4:0]  r_destroyed_x, r_sx, r_cx;
    logic [3:0]  r_destroyed_y, r_sy, r_cy;
    logic [2:0]  r_range, r_k;
    logic [1:0]  r_arm;

    logic        w_we, w_accept, w_end_arm, w_step, w_clear, w_init_last;
    logic [8:0]  w_waddr, w_taddr;
    logic [3:0]  w_wdata, w_fill;
    logic [5:0]  w_tx, w_ty, w_k6;
    logic        w_outside, w_border, w_pillar, w_spawn, w_brick;
    logic [4:0]  w_rx;
    logic [3:0]  w_ry;

    // Fill rule for the sweep pointer; first match wins
    assign w_init_last = (r_sx == 5'(MAP_W - 1)) && (r_sy == 4'(MAP_H - 1));
    assign w_border = (r_sx == 5'd0) || (r_sx == 5'(MAP_W - 1)) ||
                      (r_sy == 4'd0) || (r_sy == 4'(MAP_H - 1));
    assign w_pillar = ~r_sx[0] & ~r_sy[0];
    assign w_rx     = 5'(MAP_W - 1) - r_sx;
    assign w_ry     = 4'(MAP_H - 1) - r_sy;
    assign w_spawn  = (({1'b0, r_sx} + {2'b00, r_sy}) <= 6'd3) ||
                      (({1'b0, w_rx} + {2'b00, w_ry}) <= 6'd3);

`ifdef WALL_MAP_RANDOM_EN
    logic [15:0] r_lfsr;
    assign w_brick = r_lfsr[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_lfsr <= 16'hACE1;
        else if (r_state == S_INIT)
            r_lfsr <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
    end
`else
    assign w_brick = r_sx[0] ^ r_sy[0];
`endif

    assign w_fill = w_border ? TILE_SOLID :
                    w_pillar ? TILE_SOLID :
                    w_spawn  ? TILE_EMPTY :
                    w_brick  ? TILE_BRICK : TILE_EMPTY;

    // Blast target in 6-bit two's complement: negatives wrap above the map
    always_comb begin
        w_k6 = {3'b000, r_k};
        w_tx = {1'b0, r_cx};
        w_ty = {2'b00, r_cy};
        case (r_arm)
            2'd0:    w_ty = {2'b00, r_cy} - w_k6;
            2'd1:    w_ty = {2'b00, r_cy} + w_k6;
            2'd2:    w_tx = {1'b0, r_cx} - w_k6;
            default: w_tx = {1'b0, r_cx} + w_k6;
        endcase
    end

    assign w_outside = (w_tx >= 6'(MAP_W)) || (w_ty >= 6'(MAP_H));
    assign w_taddr   = {w_ty[3:0], w_tx[4:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_INIT;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        w_waddr     = {r_sy, r_sx};
        w_wdata     = w_fill;
        w_accept    = 1'b0;
        w_end_arm   = 1'b0;
        w_step      = 1'b0;
        w_clear     = 1'b0;
        case (r_state)
            S_INIT: begin
                w_we = 1'b1;
                if (w_init_last)
                    w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (expl_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_ARM_RD;
                end
            end
            S_ARM_RD: begin
                w_state_nxt = (r_range == 3'd0) ? S_IDLE : S_ARM_CHK;
            end
            S_ARM_CHK: begin
                if (w_outside || (r_eng_q == TILE_SOLID)) begin
                    w_end_arm = 1'b1;
                end else if (r_eng_q == TILE_BRICK) begin
                    w_end_arm = 1'b1;
                    w_clear   = 1'b1;
                    w_we      = 1'b1;
                    w_waddr   = w_taddr;
                    w_wdata   = TILE_EMPTY;
                end else if (r_k == r_range) begin
                    w_end_arm = 1'b1;
                end else begin
                    w_step = 1'b1;
                end
                w_state_nxt = (w_end_arm && (r_arm == 2'd3)) ? S_IDLE : S_ARM_RD;
            end
            default: w_state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sx              <= 5'd0;
            r_sy              <= 4'd0;
            r_init_done       <= 1'b0;
            r_cx              <= 5'd0;
            r_cy              <= 4'd0;
            r_range           <= 3'd0;
            r_arm             <= 2'd0;
            r_k               <= 3'd1;
            r_destroyed_valid <= 1'b0;
            r_destroyed_x     <= 5'd0;
            r_destroyed_y     <= 4'd0;
        end else begin
            if (r_state == S_INIT) begin
                if (r_sx == 5'(MAP_W - 1)) begin
                    r_sx <= 5'd0;
                    r_sy <= r_sy + 4'd1;
                end else begin
                    r_sx <= r_sx + 5'd1;
                end
                if (w_init_last)
                    r_init_done <= 1'b1;
            end
            if (w_accept) begin
                r_cx    <= expl_tileX;
                r_cy    <= expl_tileY;
                r_range <= expl_range;
                r_arm   <= 2'd0;
                r_k     <= 3'd1;
            end
            if (w_step)
                r_k <= r_k + 3'd1;
            if (w_end_arm) begin
                r_arm <= r_arm + 2'd1;
                r_k   <= 3'd1;
            end
            r_destroyed_valid <= w_clear;
            if (w_clear) begin
                r_destroyed_x <= w_tx[4:0];
                r_destroyed_y <= w_ty[3:0];
            end
        end
    end

    // Map storage is not reset; a fresh INIT sweep rebuilds it
    always_ff @(posedge clk) begin
        if (w_we)
            r_mem[w_waddr] <= w_wdata;
        r_eng_q <= r_mem[w_taddr];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_rd_sprite <= TILE_EMPTY;
        else if (({1'b0, rd_tileX} >= 6'(MAP_W)) || ({1'b0, rd_tileY} >= 5'(MAP_H)))
            r_rd_sprite <= TILE_EMPTY;
        else
            r_rd_sprite <= r_mem[{rd_tileY, rd_tileX}];
    end

    assign rd_sprite       = r_rd_sprite;
    assign init_done       = r_init_done;
    assign expl_ready      = (r_state == S_IDLE);
    assign destroyed_valid = r_destroyed_valid;
    assign destroyed_tileX = r_destroyed_x;
    assign destroyed_tileY = r_destroyed_y;

endmodule
`default_nettype wire
